// File: rtl/ttl16_pkg.sv
// ttl16_pkg -- shared constants for the TTL16 datapath.
//
// Holds the datapath word width, the register count and select width, and
// the bit positions of the ALU status flags as they travel on flags_in /
// flags_out ({overflow, less, equal, greater, zero}, bit 4 down to bit 0).
package ttl16_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int SEL_W    = $clog2(NUM_REGS);

  localparam int FLAG_W    = 5;
  localparam int FLAG_OVF  = 4;
  localparam int FLAG_LESS = 3;
  localparam int FLAG_EQ   = 2;
  localparam int FLAG_GT   = 1;
  localparam int FLAG_ZERO = 0;

endpackage

// File: rtl/reg_file_status_flags.sv
// status_flags -- registered ALU status flags plus a sticky overflow bit.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset; clears flags and sticky bit
//   flag_wr_en  load flags_in into flags_out on the edge
//   flags_in    ALU flags {ovf, less, eq, gt, zero}
//   clr_sticky  clear ovf_sticky (loses against a simultaneous set)
//   flags_out   registered flags, same bit order as flags_in
//   ovf_sticky  set by any flag load carrying overflow, held until cleared
module status_flags (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flag_wr_en,
  input  logic [ttl16_pkg::FLAG_W-1:0]  flags_in,
  input  logic                          clr_sticky,
  output logic [ttl16_pkg::FLAG_W-1:0]  flags_out,
  output logic                          ovf_sticky
);
  import ttl16_pkg::*;

  logic stickySet;

  // A flag load carrying overflow sets the sticky bit; it outranks a clear
  // in the same cycle so an overflow can never be silently lost.
  assign stickySet = flag_wr_en && flags_in[FLAG_OVF];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_out  <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (flag_wr_en) begin
        flags_out <= flags_in;
      end
      if (stickySet) begin
        ovf_sticky <= 1'b1;
      end else if (clr_sticky) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file -- two-read, one-write register file with write-first bypass,
// feeding the ALU operands, plus the status-flag register.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   rd_sel_a / rd_sel_b   read selects for a_out / b_out (combinational)
//   a_out / b_out         ALU A / B operands
//   wr_en, wr_sel,        write strobe, destination and data (r0 is
//   wr_data               hard-wired to zero and ignores writes)
//   flag_wr_en, flags_in  status-flag load strobe and ALU flags
//   clr_sticky            clear sticky overflow
//   flags_out, ovf_sticky registered flags and sticky overflow
module reg_file #(
  parameter int DATA_W   = ttl16_pkg::DATA_W,
  parameter int NUM_REGS = ttl16_pkg::NUM_REGS,
  localparam int SEL_W   = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SEL_W-1:0]              rd_sel_a,
  input  logic [SEL_W-1:0]              rd_sel_b,
  output logic [DATA_W-1:0]             a_out,
  output logic [DATA_W-1:0]             b_out,
  input  logic                          wr_en,
  input  logic [SEL_W-1:0]              wr_sel,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          flag_wr_en,
  input  logic [ttl16_pkg::FLAG_W-1:0]  flags_in,
  output logic [ttl16_pkg::FLAG_W-1:0]  flags_out,
  output logic                          ovf_sticky,
  input  logic                          clr_sticky
);
  import ttl16_pkg::*;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              writeLive;
  logic              bypassA;
  logic              bypassB;

  // A write only counts when reset is not asserted and the target is not r0.
  assign writeLive = rst_n && wr_en && (wr_sel != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (writeLive) begin
      regs[wr_sel] <= wr_data;
    end
  end

  // Write-first bypass: a read of the register being written this cycle sees
  // the incoming data. Each port decides independently. r0 always reads zero
  // regardless of what is stored or written.
  assign bypassA = writeLive && (rd_sel_a == wr_sel);
  assign bypassB = writeLive && (rd_sel_b == wr_sel);

  assign a_out = (rd_sel_a == '0) ? '0 : (bypassA ? wr_data : regs[rd_sel_a]);
  assign b_out = (rd_sel_b == '0) ? '0 : (bypassB ? wr_data : regs[rd_sel_b]);

  status_flags uStatusFlags (
    .clk        (clk),
    .rst_n      (rst_n),
    .flag_wr_en (flag_wr_en),
    .flags_in   (flags_in),
    .clr_sticky (clr_sticky),
    .flags_out  (flags_out),
    .ovf_sticky (ovf_sticky)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file -- self-checking bench for reg_file. A behavioural model
// (plain array of words, a flag word and a sticky bit) predicts every read
// port value before the edge and every registered value after it.
module tb_reg_file;

  logic        clk;
  logic        rstN;
  logic [2:0]  rdSelA;
  logic [2:0]  rdSelB;
  logic [15:0] aOut;
  logic [15:0] bOut;
  logic        wrEn;
  logic [2:0]  wrSel;
  logic [15:0] wrData;
  logic        flagWrEn;
  logic [4:0]  flagsIn;
  logic [4:0]  flagsOut;
  logic        ovfSticky;
  logic        clrSticky;

  int checks = 0;
  int errors = 0;

  logic [15:0] modelMem [8];
  logic [4:0]  modelFlags;
  logic        modelSticky;

  reg_file dut (
    .clk        (clk),
    .rst_n      (rstN),
    .rd_sel_a   (rdSelA),
    .rd_sel_b   (rdSelB),
    .a_out      (aOut),
    .b_out      (bOut),
    .wr_en      (wrEn),
    .wr_sel     (wrSel),
    .wr_data    (wrData),
    .flag_wr_en (flagWrEn),
    .flags_in   (flagsIn),
    .flags_out  (flagsOut),
    .ovf_sticky (ovfSticky),
    .clr_sticky (clrSticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value a read port must show for the current inputs.
  function automatic logic [15:0] expectRead(input logic [2:0] sel);
    if (sel == 3'd0) return 16'h0000;
    if (rstN && wrEn && sel == wrSel) return wrData;
    return modelMem[sel];
  endfunction

  // Clock edge plus the model's view of what that edge does.
  task automatic tick();
    @(posedge clk);
    if (!rstN) begin
      for (int i = 0; i < 8; i++) modelMem[i] = 16'h0000;
      modelFlags  = 5'b0;
      modelSticky = 1'b0;
    end else begin
      if (wrEn && wrSel != 3'd0) modelMem[wrSel] = wrData;
      if (flagWrEn) modelFlags = flagsIn;
      if (flagWrEn && flagsIn[4]) modelSticky = 1'b1;
      else if (clrSticky) modelSticky = 1'b0;
    end
    #1;
  endtask

  task automatic applyIdle();
    @(negedge clk);
    rstN = 1'b1; wrEn = 1'b0; wrSel = 3'd0; wrData = 16'h0;
    flagWrEn = 1'b0; flagsIn = 5'b0; clrSticky = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstN = 1'b0; wrEn = 1'b1; wrSel = 3'd2; wrData = 16'h1111;
    flagWrEn = 1'b1; flagsIn = 5'b11111; clrSticky = 1'b0;
    rdSelA = 3'd0; rdSelB = 3'd0;
    tick();
    checks++;
    if (flagsOut !== 5'b0 || ovfSticky !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b/%b expected 00000/0", flagsOut, ovfSticky);
    end
    applyIdle();
    for (int i = 0; i < 8; i++) begin
      rdSelA = 3'(i); rdSelB = 3'(7 - i);
      #1;
      checks++;
      if (aOut !== 16'h0 || bOut !== 16'h0) begin
        errors++;
        $display("[TB] FAIL reset_read sel=%0d: got a=%h b=%h expected 0000", i, aOut, bOut);
      end
    end
    // Write 0xBEEF to r3 while reading it on port A.
    @(negedge clk);
    wrEn = 1'b1; wrSel = 3'd3; wrData = 16'hBEEF; rdSelA = 3'd3;
    #1;
    checks++;
    if (aOut !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL beef_bypass: got %h expected beef", aOut);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      applyIdle();
      rdSelA = 3'd3;
      #1;
      checks++;
      if (aOut !== 16'hBEEF) begin
        errors++;
        $display("[TB] FAIL beef_hold cycle %0d: got %h expected beef", c, aOut);
      end
      tick();
    end
  endtask

  task automatic test_r0();
    @(negedge clk);
    rstN = 1'b1; wrEn = 1'b1; wrSel = 3'd0; wrData = 16'h1234;
    rdSelA = 3'd0; rdSelB = 3'd0;
    #1;
    checks++;
    if (aOut !== 16'h0 || bOut !== 16'h0) begin
      errors++;
      $display("[TB] FAIL r0_same_cycle: got a=%h b=%h expected 0000", aOut, bOut);
    end
    tick();
    applyIdle();
    rdSelA = 3'd0; rdSelB = 3'd0;
    #1;
    checks++;
    if (aOut !== 16'h0 || bOut !== 16'h0) begin
      errors++;
      $display("[TB] FAIL r0_after: got a=%h b=%h expected 0000", aOut, bOut);
    end
  endtask

  task automatic test_dual_bypass();
    @(negedge clk);
    wrEn = 1'b1; wrSel = 3'd7; wrData = 16'h5A5A;
    tick();
    @(negedge clk);
    wrEn = 1'b1; wrSel = 3'd7; wrData = 16'hFFFF;
    rdSelA = 3'd7; rdSelB = 3'd7;
    #1;
    checks++;
    if (aOut !== 16'hFFFF || bOut !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL dual_bypass: got a=%h b=%h expected ffff", aOut, bOut);
    end
    tick();
    applyIdle();
    rdSelA = 3'd7; rdSelB = 3'd7;
    #1;
    checks++;
    if (aOut !== 16'hFFFF || bOut !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL r7_stored: got a=%h b=%h expected ffff", aOut, bOut);
    end
  endtask

  task automatic test_flags();
    @(negedge clk);
    flagWrEn = 1'b1; flagsIn = 5'b10001; clrSticky = 1'b0;
    #1;
    checks++;
    if (flagsOut === 5'b10001) begin
      errors++;
      $display("[TB] FAIL flags_not_bypassed: got %b expected previous value", flagsOut);
    end
    tick();
    checks++;
    if (flagsOut !== 5'b10001 || ovfSticky !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flags_load: got %b/%b expected 10001/1", flagsOut, ovfSticky);
    end
    @(negedge clk);
    flagWrEn = 1'b1; flagsIn = 5'b00100; clrSticky = 1'b0;
    tick();
    checks++;
    if (flagsOut !== 5'b00100 || ovfSticky !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sticky_hold: got %b/%b expected 00100/1", flagsOut, ovfSticky);
    end
    applyIdle();
    tick();
    checks++;
    if (flagsOut !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL flags_hold: got %b expected 00100", flagsOut);
    end
  endtask

  task automatic test_sticky_race();
    @(negedge clk);
    flagWrEn = 1'b1; flagsIn = 5'b10000; clrSticky = 1'b1;
    tick();
    checks++;
    if (ovfSticky !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sticky_set_wins: got %b expected 1", ovfSticky);
    end
    applyIdle();
    clrSticky = 1'b1;
    tick();
    checks++;
    if (ovfSticky !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sticky_clear: got %b expected 0", ovfSticky);
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    rstN = 1'b1; wrEn = 1'b1; wrSel = 3'd5; wrData = 16'h3C3C;
    flagWrEn = 1'b1; flagsIn = 5'b01010;
    tick();
    @(negedge clk);
    rstN = 1'b0; wrEn = 1'b1; wrSel = 3'd5; wrData = 16'hAAAA;
    flagWrEn = 1'b1; flagsIn = 5'b11111; rdSelA = 3'd5;
    #1;
    checks++;
    if (aOut !== 16'h3C3C) begin
      errors++;
      $display("[TB] FAIL reset_no_bypass: got %h expected 3c3c", aOut);
    end
    tick();
    checks++;
    if (flagsOut !== 5'b0 || ovfSticky !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_flags: got %b/%b expected 00000/0", flagsOut, ovfSticky);
    end
    applyIdle();
    rdSelA = 3'd5;
    #1;
    checks++;
    if (aOut !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_r5: got %h expected 0000", aOut);
    end
  endtask

  task automatic test_random();
    logic [15:0] expA, expB;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rstN      = ($urandom_range(0, 31) != 0);
      wrEn      = $urandom_range(0, 1) == 1;
      wrSel     = 3'($urandom);
      wrData    = 16'($urandom);
      flagWrEn  = $urandom_range(0, 2) == 0;
      flagsIn   = 5'($urandom);
      clrSticky = $urandom_range(0, 3) == 0;
      rdSelA    = ($urandom_range(0, 3) == 0) ? wrSel : 3'($urandom);
      rdSelB    = ($urandom_range(0, 3) == 0) ? wrSel : 3'($urandom);
      #1;
      expA = expectRead(rdSelA);
      expB = expectRead(rdSelB);
      checks++;
      if (aOut !== expA || bOut !== expB) begin
        errors++;
        $display("[TB] FAIL random_read %0d: got a=%h b=%h expected a=%h b=%h",
                 n, aOut, bOut, expA, expB);
      end
      tick();
      checks++;
      if (flagsOut !== modelFlags || ovfSticky !== modelSticky) begin
        errors++;
        $display("[TB] FAIL random_flags %0d: got %b/%b expected %b/%b",
                 n, flagsOut, ovfSticky, modelFlags, modelSticky);
      end
    end
  endtask

  initial begin
    rstN = 1'b1; wrEn = 1'b0; wrSel = 3'd0; wrData = 16'h0;
    flagWrEn = 1'b0; flagsIn = 5'b0; clrSticky = 1'b0;
    rdSelA = 3'd0; rdSelB = 3'd0;
    for (int i = 0; i < 8; i++) modelMem[i] = 16'h0000;
    modelFlags = 5'b0;
    modelSticky = 1'b0;
    test_reset();
    test_r0();
    test_dual_bypass();
    test_flags();
    test_sticky_race();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
